// File: rtl/platform_scroll_if.sv
// Platform register-file port: combinational read by index, one write per strobe.
// Master is the scroll sequencer and the slave is the platform table.
interface platform_scroll_if #(
   parameter int IDX_W = 4
);
   logic [IDX_W-1:0] rd_idx;
   logic [8:0]       rd_x;
   logic [8:0]       rd_y;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [8:0]       wr_x;
   logic [8:0]       wr_y;

   modport master (output rd_idx, wr_en, wr_idx, wr_x, wr_y, input rd_x, rd_y);
   modport slave  (input rd_idx, wr_en, wr_idx, wr_x, wr_y, output rd_x, rd_y);
endinterface

// File: rtl/platform_scroll_sequencer.sv
// Per-frame platform scroll sweep with respawn; PLAT_SCROLL_STATS_EN builds the respawn counter.
// First write 3 Clk after a tick, 34-Clk sweep; ticks while busy queue one deep, then flag overrun.
module platform_scroll_sequencer #(
   parameter int          NUM_PLAT  = 16,
   parameter int          Y_MAX     = 479,
   parameter int          X_MIN     = 40,
   parameter int          X_SPAN    = 512,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_clk,
   input  logic               scroll_en,
   input  logic [7:0]         scroll_amt,
   platform_scroll_if.master  pif,
   output logic               busy,
   output logic               done,
   output logic               overrun,
   output logic [15:0]        respawn_cnt
);
   localparam int IDX_W = $clog2(NUM_PLAT);
   localparam int XS_W  = $clog2(X_SPAN);

   typedef enum logic [2:0] {IDLE, LOAD, RD, WR, DONE} state_t;

   state_t           state, state_nxt;
   logic             frame_q;
   logic             tick;
   logic             acc_tick;
   logic             pending;
   logic [7:0]       amt_q;
   logic [IDX_W-1:0] idx;
   logic [8:0]       x_q, y_q;
   logic [15:0]      lfsr, lfsr_nxt;
   logic [9:0]       ny;
   logic             respawn;
   logic [8:0]       x_new, y_new;
   logic             last_slot;

   assign tick      = frame_clk & ~frame_q;
   assign acc_tick  = tick & scroll_en & (scroll_amt != 8'd0);
   assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   assign ny        = {1'b0, y_q} + {2'b00, amt_q};
   assign respawn   = (ny > 10'(Y_MAX));
   assign y_new     = respawn ? 9'(ny - 10'(Y_MAX + 1)) : ny[8:0];
   // Respawn X wraps mod 512 if the window runs past the right edge.
   assign x_new     = respawn ? 9'(X_MIN) + 9'(lfsr_nxt[XS_W-1:0]) : x_q;
   assign last_slot = (idx == IDX_W'(NUM_PLAT - 1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc_tick || pending) state_nxt = LOAD;
         LOAD:    state_nxt = RD;
         RD:      state_nxt = WR;
         WR:      state_nxt = last_slot ? DONE : RD;
         DONE:    state_nxt = (pending || acc_tick) ? LOAD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_q    <= 1'b0;
         pending    <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         amt_q      <= 8'd0;
         idx        <= '0;
         x_q        <= 9'd0;
         y_q        <= 9'd0;
         lfsr       <= LFSR_SEED;
         pif.rd_idx <= '0;
         pif.wr_en  <= 1'b0;
         pif.wr_idx <= '0;
         pif.wr_x   <= 9'd0;
         pif.wr_y   <= 9'd0;
      end else begin
         frame_q   <= frame_clk;
         pif.wr_en <= 1'b0;
         busy      <= (state_nxt != IDLE);
         done      <= (state_nxt == DONE);
         case (state)
            LOAD: begin
               amt_q      <= scroll_amt;
               idx        <= '0;
               pif.rd_idx <= '0;
               pending    <= 1'b0;
            end
            RD: begin
               x_q <= pif.rd_x;
               y_q <= pif.rd_y;
            end
            WR: begin
               pif.wr_en  <= 1'b1;
               pif.wr_idx <= idx;
               pif.wr_x   <= x_new;
               pif.wr_y   <= y_new;
               if (respawn) lfsr <= lfsr_nxt;
               if (!last_slot) begin
                  idx        <= idx + 1'b1;
                  pif.rd_idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
         // A tick during LOAD is a fresh request: the old pending is being consumed.
         if (acc_tick && state != IDLE) begin
            if (pending && state != LOAD) overrun <= 1'b1;
            else                          pending <= 1'b1;
         end
      end
   end

`ifdef PLAT_SCROLL_STATS_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                  respawn_cnt <= 16'h0000;
      else if (state == WR && respawn) respawn_cnt <= respawn_cnt + 16'd1;
   end
`else
   assign respawn_cnt = 16'h0000;
`endif

endmodule
